// File: rtl/key_input_port.sv
// Memory-mapped push-button port: synchronizer, programmable debounce, edge capture, press counter.
// Optional interrupt logic is built when KEY_IRQ_EN is defined.
module key_input_port #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic             s1_r;
    logic             s2_r;
    logic             lvl_r;
    logic             lvl_d_r;
    logic [7:0]       dbc_r;
    logic [7:0]       thr_r;
    logic [7:0]       thr_eff_s;
    logic [1:0]       edge_r;
    logic [1:0]       edge_clr_s;
    logic [1:0]       mask_s;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      rdata_r;
    logic [31:0]      rd_mux_s;
    logic             rise_s;
    logic             fall_s;
    logic             rd_s;
    logic             wr_edge_s;
    logic             wr_count_s;
    logic             wr_cfg_s;
    logic             unused_s;

    assign unused_s = &{1'b0, wdata};

    // Bus decode, effective threshold and edge detection
    always_comb begin
        rise_s     = lvl_r & ~lvl_d_r;
        fall_s     = ~lvl_r & lvl_d_r;
        rd_s       = sel & ~we;
        wr_edge_s  = sel & we & (addr == 2'd1);
        wr_count_s = sel & we & (addr == 2'd2);
        wr_cfg_s   = sel & we & (addr == 2'd3);
        if (thr_r == 8'd0) begin
            thr_eff_s = 8'd1;
        end else begin
            thr_eff_s = thr_r;
        end
        if (wr_edge_s) begin
            edge_clr_s = wdata[1:0];
        end else begin
            edge_clr_s = 2'b00;
        end
    end

    // Read-data multiplexer over the current register values
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr)
            2'd0:    rd_mux_s = {30'd0, s2_r, lvl_r};
            2'd1:    rd_mux_s = {30'd0, edge_r};
            2'd2:    rd_mux_s = 32'(count_r);
            2'd3:    rd_mux_s = {22'd0, mask_s, thr_r};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Synchronizer and debounce filter; >= lets a lowered threshold take effect immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            lvl_r   <= 1'b0;
            lvl_d_r <= 1'b0;
            dbc_r   <= 8'd0;
        end else begin
            s1_r    <= key;
            s2_r    <= s1_r;
            lvl_d_r <= lvl_r;
            if (s2_r == lvl_r) begin
                dbc_r <= 8'd0;
            end else if (dbc_r >= thr_eff_s - 8'd1) begin
                lvl_r <= s2_r;
                dbc_r <= 8'd0;
            end else begin
                dbc_r <= dbc_r + 8'd1;
            end
        end
    end

    // Sticky edge flags, press counter, threshold and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_r  <= 2'b00;
            count_r <= '0;
            thr_r   <= 8'(DEBOUNCE_CYCLES);
            rdata_r <= 32'd0;
        end else begin
            edge_r <= (edge_r & ~edge_clr_s) | {fall_s, rise_s};
            if (wr_count_s) begin
                count_r <= rise_s ? CNT_W'(1) : CNT_W'(0);
            end else if (rise_s) begin
                count_r <= count_r + CNT_W'(1);
            end
            if (wr_cfg_s) begin
                thr_r <= wdata[7:0];
            end
            if (rd_s) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    assign rdata = rdata_r;

`ifdef KEY_IRQ_EN
    logic [1:0] mask_r;
    logic       irq_r;

    // Interrupt mask and registered interrupt request
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= 2'b00;
            irq_r  <= 1'b0;
        end else begin
            if (wr_cfg_s) begin
                mask_r <= wdata[9:8];
            end
            irq_r <= |(edge_r & mask_r);
        end
    end

    assign mask_s = mask_r;
    assign irq    = irq_r;
`else
    assign mask_s = 2'b00;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_key_input_port.sv
// Scoreboard bench for key_input_port: reads push expected data, a monitor pops and compares.
module tb_key_input_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        key;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int tests_run = 0;
    int failures  = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_fire_r = 1'b0;

    key_input_port #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .key(key), .sel(sel), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a read sampled at a rising edge is checked at the following falling edge
    always @(posedge clk) rd_fire_r <= sel && !we && !rst;

    always @(negedge clk) begin
        if (rd_fire_r) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                failures++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", rdata);
            end else begin
                check(name_q.pop_front(), rdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic press(input int hold);
        key = 1'b1;
        tick(hold);
        key = 1'b0;
        tick(hold);
    endtask

    initial begin
        rst = 1'b1; key = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        tick(2);
        rst = 1'b0;
        check("reset_rdata", rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rd(2'd0, 32'h0, "reset_status");
        rd(2'd1, 32'h0, "reset_edge");
        rd(2'd2, 32'h0, "reset_count");
        rd(2'd3, 32'h4, "reset_config");

        // Glitch shorter than the threshold of 4
        key = 1'b1;
        tick(3);
        key = 1'b0;
        tick(8);
        rd(2'd0, 32'h0, "glitch_status");
        rd(2'd1, 32'h0, "glitch_edge");
        rd(2'd2, 32'h0, "glitch_count");

        // Press: lvl follows at edge N+5
        key = 1'b1;
        tick(5);
        rd(2'd0, 32'h2, "press_status_before");
        rd(2'd0, 32'h3, "press_status_after");
        tick(13);
        key = 1'b0;
        tick(8);
        rd(2'd1, 32'h3, "release_edge");
        rd(2'd2, 32'h1, "release_count");
        rd(2'd0, 32'h0, "release_status");

        // W1C clear coinciding with a new rise
        wr(2'd1, 32'h2);
        rd(2'd1, 32'h1, "w1c_partial");
        key = 1'b1;
        tick(6);
        wr(2'd1, 32'h1);
        tick(3);
        rd(2'd1, 32'h1, "w1c_race_edge");
        rd(2'd2, 32'h2, "w1c_race_count");
        key = 1'b0;
        tick(8);
        rd(2'd1, 32'h3, "w1c_release_edge");

        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, 32'h0, "status_write_ignored");

        // Threshold 0 behaves as 1: lvl at edge N+2
        wr(2'd3, 32'h0);
        rd(2'd3, 32'h0, "config_thr0");
        key = 1'b1;
        tick(2);
        rd(2'd0, 32'h2, "thr0_status_before");
        rd(2'd0, 32'h3, "thr0_status_after");
        key = 1'b0;
        tick(4);

        // Counter wrap with CNT_W=4
        wr(2'd3, 32'h1);
        wr(2'd2, 32'h0);
        rd(2'd2, 32'h0, "count_cleared");
        for (int i = 0; i < 15; i++) press(4);
        rd(2'd2, 32'hF, "count_15");
        press(4);
        rd(2'd2, 32'h0, "count_wrap");
        press(4);
        rd(2'd2, 32'h1, "count_after_wrap");
        key = 1'b1;
        tick(3);
        wr(2'd2, 32'h0);
        tick(2);
        rd(2'd2, 32'h1, "count_write_rise_race");
        key = 1'b0;
        tick(4);

        wr(2'd1, 32'h3);
`ifdef KEY_IRQ_EN
        wr(2'd3, 32'h101);
        rd(2'd3, 32'h101, "irq_config");
        key = 1'b1;
        tick(4);
        check("irq_not_yet", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq_set", {31'd0, irq}, 32'd1);
        wr(2'd1, 32'h1);
        check("irq_held_at_clear", {31'd0, irq}, 32'd1);
        tick(1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        key = 1'b0;
        tick(6);
        check("irq_fall_masked", {31'd0, irq}, 32'd0);
`else
        wr(2'd3, 32'h301);
        rd(2'd3, 32'h1, "config_mask_absent");
        key = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("irq_tied_low", {31'd0, irq}, 32'd0);
        end
        key = 1'b0;
        tick(6);
`endif

        tick(3);
        tests_run++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_reads: got %0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
